// File: rtl/regfile_3r2w_pkg.sv
// Shared constants for the ARM32 register file: architectural register indices
// and the default r15 read offset.
package regfile_3r2w_pkg;

  localparam int unsigned NumRegs  = 15;
  localparam int unsigned DataW    = 32;
  localparam int unsigned IdxW     = 4;

  localparam logic [IdxW-1:0]  RegLr     = 4'd14;
  localparam logic [IdxW-1:0]  RegPc     = 4'd15;
  localparam logic [DataW-1:0] PcReadOfs = 32'd8;

  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;

  typedef logic [NumRegs-1:0][DataW-1:0] reg_array_t;

endpackage

// File: rtl/regfile_3r2w_read_port.sv
// One combinational read port: virtualised r15, optional same-cycle forwarding
// from the two write ports (port 1 first), otherwise the stored value.
module regfile_3r2w_read_port
  import regfile_3r2w_pkg::*;
#(
  parameter bit               Bypass = 1'b1,
  parameter logic [DataW-1:0] PcOfs  = PcReadOfs
) (
  input  logic [IdxW-1:0]  idx_i,
  input  reg_array_t       regs_i,
  input  logic [DataW-1:0] pc_i,
  input  logic             we1_i,
  input  logic [IdxW-1:0]  ws1_i,
  input  logic [DataW-1:0] wd1_i,
  input  logic             we2_i,
  input  logic [IdxW-1:0]  ws2_i,
  input  logic [DataW-1:0] wd2_i,
  output logic [DataW-1:0] data_o
);

  always_comb begin
    data_o = '0;
    if (idx_i == RegPc) begin
      data_o = pc_i + PcOfs;
    end else if (Bypass && we1_i && (ws1_i == idx_i)) begin
      data_o = wd1_i;
    end else if (Bypass && we2_i && (ws2_i == idx_i)) begin
      data_o = wd2_i;
    end else begin
      data_o = regs_i[idx_i];
    end
  end

endmodule

// File: rtl/regfile_3r2w.sv
// ARM32 register file, r0..r14 stored, r15 read as pc+PC_OFS; r15 writes are
// captured into a registered pc_wr/pc_wdata redirect pulse.
module regfile_3r2w
  import regfile_3r2w_pkg::*;
#(
  parameter bit          BYPASS = 1'b1,
  parameter logic [31:0] PC_OFS = PcReadOfs
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  rs1,
  input  logic [3:0]  rs2,
  input  logic [3:0]  rs3,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  output logic [31:0] rd3,
  input  logic [3:0]  ws1,
  input  logic [31:0] wd1,
  input  logic        we1,
  input  logic [3:0]  ws2,
  input  logic [31:0] wd2,
  input  logic        we2,
  input  logic [31:0] pc,
  output logic        pc_wr,
  output logic [31:0] pc_wdata,
  input  logic [3:0]  dbg_idx,
  output logic [31:0] dbg_data
);

  reg_array_t  regs_q, regs_d;
  logic        pc_wr_q, pc_wr_d;
  logic [31:0] pc_wdata_q, pc_wdata_d;
  logic        we1_arr, we2_arr, we1_pc, we2_pc;
  logic        fwd_we1, fwd_we2;

  assign we1_arr = we1 && (ws1 != RegPc);
  assign we2_arr = we2 && (ws2 != RegPc);
  assign we1_pc  = we1 && (ws1 == RegPc);
  assign we2_pc  = we2 && (ws2 == RegPc);

  // Nothing lands during reset, so nothing may be forwarded either.
  assign fwd_we1 = we1 && rst_n;
  assign fwd_we2 = we2 && rst_n;

  always_comb begin
    regs_d = regs_q;
    // Port 2 first so a colliding port 1 write overrides it.
    if (we2_arr) regs_d[ws2] = wd2;
    if (we1_arr) regs_d[ws1] = wd1;
  end

  always_comb begin
    pc_wr_d    = we1_pc || we2_pc;
    pc_wdata_d = pc_wdata_q;
    if (we1_pc) begin
      pc_wdata_d = wd1;
    end else if (we2_pc) begin
      pc_wdata_d = wd2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q     <= '0;
      pc_wr_q    <= False;
      pc_wdata_q <= '0;
    end else begin
      regs_q     <= regs_d;
      pc_wr_q    <= pc_wr_d;
      pc_wdata_q <= pc_wdata_d;
    end
  end

  assign pc_wr    = pc_wr_q;
  assign pc_wdata = pc_wdata_q;
  assign dbg_data = (dbg_idx == RegPc) ? (pc + PC_OFS) : regs_q[dbg_idx];

  regfile_3r2w_read_port #(.Bypass(BYPASS), .PcOfs(PC_OFS)) u_rp1 (
    .idx_i (rs1), .regs_i(regs_q), .pc_i(pc),
    .we1_i (fwd_we1), .ws1_i(ws1), .wd1_i(wd1),
    .we2_i (fwd_we2), .ws2_i(ws2), .wd2_i(wd2),
    .data_o(rd1)
  );

  regfile_3r2w_read_port #(.Bypass(BYPASS), .PcOfs(PC_OFS)) u_rp2 (
    .idx_i (rs2), .regs_i(regs_q), .pc_i(pc),
    .we1_i (fwd_we1), .ws1_i(ws1), .wd1_i(wd1),
    .we2_i (fwd_we2), .ws2_i(ws2), .wd2_i(wd2),
    .data_o(rd2)
  );

  regfile_3r2w_read_port #(.Bypass(BYPASS), .PcOfs(PC_OFS)) u_rp3 (
    .idx_i (rs3), .regs_i(regs_q), .pc_i(pc),
    .we1_i (fwd_we1), .ws1_i(ws1), .wd1_i(wd1),
    .we2_i (fwd_we2), .ws2_i(ws2), .wd2_i(wd2),
    .data_o(rd3)
  );

endmodule

// File: tb/tb_regfile_3r2w.sv
// Directed bench for regfile_3r2w: a BYPASS=1 instance plus a BYPASS=0 instance
// sharing the same stimulus.
module tb_regfile_3r2w;

  logic        clk, rst_n;
  logic [3:0]  rs1, rs2, rs3, ws1, ws2, dbg_idx;
  logic [31:0] wd1, wd2, pc;
  logic        we1, we2;

  logic [31:0] rd1, rd2, rd3, pc_wdata, dbg_data;
  logic        pc_wr;
  logic [31:0] nb_rd1, nb_rd2, nb_rd3, nb_pc_wdata, nb_dbg_data;
  logic        nb_pc_wr;

  int vectors    = 0;
  int miscompares = 0;
  logic [31:0] model [15];

  regfile_3r2w #(.BYPASS(1'b1), .PC_OFS(32'd8)) dut (
    .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2), .rs3(rs3),
    .rd1(rd1), .rd2(rd2), .rd3(rd3),
    .ws1(ws1), .wd1(wd1), .we1(we1), .ws2(ws2), .wd2(wd2), .we2(we2),
    .pc(pc), .pc_wr(pc_wr), .pc_wdata(pc_wdata),
    .dbg_idx(dbg_idx), .dbg_data(dbg_data)
  );

  regfile_3r2w #(.BYPASS(1'b0), .PC_OFS(32'd8)) dut_nb (
    .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2), .rs3(rs3),
    .rd1(nb_rd1), .rd2(nb_rd2), .rd3(nb_rd3),
    .ws1(ws1), .wd1(wd1), .we1(we1), .ws2(ws2), .wd2(wd2), .we2(we2),
    .pc(pc), .pc_wr(nb_pc_wr), .pc_wdata(nb_pc_wdata),
    .dbg_idx(dbg_idx), .dbg_data(nb_dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_writes();
    we1 = 1'b0; we2 = 1'b0; ws1 = 4'd0; ws2 = 4'd0; wd1 = '0; wd2 = '0;
  endtask

  task automatic scan(input string tag);
    for (int i = 0; i < 15; i++) begin
      dbg_idx = 4'(i);
      #1;
      check($sformatf("%s_r%0d", tag, i), dbg_data, model[i]);
    end
  endtask

  initial begin
    for (int i = 0; i < 15; i++) model[i] = '0;
    rst_n = 1'b0; rs1 = '0; rs2 = '0; rs3 = '0; dbg_idx = '0; pc = '0;
    idle_writes();
    step();
    step();
    rst_n = 1'b1;
    #1;
    check("reset_rd1", rd1, 32'h0);
    check("reset_pc_wr", {31'b0, pc_wr}, 32'h0);

    // Write r3, same-cycle bypass vs. no bypass
    we1 = 1'b1; ws1 = 4'd3; wd1 = 32'hDEADBEEF; rs1 = 4'd3;
    #1;
    check("bypass_rd1", rd1, 32'hDEADBEEF);
    check("nobypass_rd1", nb_rd1, 32'h0);
    step();
    idle_writes(); model[3] = 32'hDEADBEEF;
    #1;
    check("wr_r3_rd1", rd1, 32'hDEADBEEF);
    check("wr_r3_nb_rd1", nb_rd1, 32'hDEADBEEF);

    // Collision on r5: port 1 wins both in array and in bypass
    we1 = 1'b1; ws1 = 4'd5; wd1 = 32'h11; we2 = 1'b1; ws2 = 4'd5; wd2 = 32'h22; rs2 = 4'd5;
    #1;
    check("coll_bypass_rd2", rd2, 32'h11);
    step();
    idle_writes(); model[5] = 32'h11;
    #1;
    check("coll_rd2", rd2, 32'h11);
    check("coll_nb_rd2", nb_rd2, 32'h11);

    // Dual write r2/r7; port 2 bypass on rd3
    we1 = 1'b1; ws1 = 4'd2; wd1 = 32'hA; we2 = 1'b1; ws2 = 4'd7; wd2 = 32'hB;
    rs1 = 4'd2; rs3 = 4'd7;
    #1;
    check("dual_bypass_rd3", rd3, 32'hB);
    check("dual_nb_rd3", nb_rd3, 32'h0);
    step();
    idle_writes(); model[2] = 32'hA; model[7] = 32'hB;
    #1;
    check("dual_rd1", rd1, 32'hA);
    check("dual_rd3", rd3, 32'hB);

    // r15 reads
    rs2 = 4'd15; pc = 32'h100;
    #1;
    check("pc_read", rd2, 32'h108);
    pc = 32'hFFFFFFFC;
    #1;
    check("pc_read_wrap", rd2, 32'h4);

    // r15 write: no bypass, no array change, one-cycle pulse
    pc = 32'h100;
    we1 = 1'b1; ws1 = 4'd15; wd1 = 32'h2000;
    #1;
    check("pc_wr_no_bypass", rd2, 32'h108);
    step();
    idle_writes();
    #1;
    check("pc_wr_set", {31'b0, pc_wr}, 32'h1);
    check("pc_wdata_set", pc_wdata, 32'h2000);
    scan("r15wr_scan");
    step();
    check("pc_wr_clear", {31'b0, pc_wr}, 32'h0);

    // Back-to-back r15 writes, port 1 priority when both target r15
    we2 = 1'b1; ws2 = 4'd15; wd2 = 32'h3000;
    step();
    we1 = 1'b1; ws1 = 4'd15; wd1 = 32'h4000; we2 = 1'b1; ws2 = 4'd15; wd2 = 32'h5000;
    #1;
    check("b2b_pc_wdata0", pc_wdata, 32'h3000);
    step();
    idle_writes();
    #1;
    check("b2b_pc_wr1", {31'b0, pc_wr}, 32'h1);
    check("b2b_pc_wdata1", pc_wdata, 32'h4000);
    step();
    check("b2b_pc_wr_clear", {31'b0, pc_wr}, 32'h0);

    // r15 on port 1 alongside r9 on port 2
    we1 = 1'b1; ws1 = 4'd15; wd1 = 32'h6000; we2 = 1'b1; ws2 = 4'd9; wd2 = 32'h99;
    step();
    idle_writes(); model[9] = 32'h99;
    dbg_idx = 4'd9;
    #1;
    check("mix_pc_wdata", pc_wdata, 32'h6000);
    check("mix_r9", dbg_data, 32'h99);

    // Unknown index with enables low must not write
    ws1 = 4'bxxxx; ws2 = 4'bxxxx; wd1 = 32'hFFFFFFFF; wd2 = 32'hFFFFFFFF;
    step();
    step();
    idle_writes();
    scan("xidx_scan");

    // Reset during a write: immediate clear, and the write never lands
    we1 = 1'b1; ws1 = 4'd4; wd1 = 32'h77; rs1 = 4'd4; dbg_idx = 4'd2;
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_r2", dbg_data, 32'h0);
    check("async_rst_rd1", rd1, 32'h0);
    check("async_rst_pc_wr", {31'b0, pc_wr}, 32'h0);
    step();
    idle_writes();
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) model[i] = '0;
    step();
    scan("post_rst_scan");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
